instr_decode_stage: RTL and testbench
=====================================

INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

Interface
REQ-001 SHALL have ports: clk  input  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: rst  input  1  synchronous active-high reset.
REQ-003 SHALL have ports: in_valid  input  1  fetch offers an instruction; in_instr  input  32  raw RV32 instruction word; in_pc  input  32  its address.
REQ-004 SHALL have ports: in_ready  output  1  stage accepts this cycle; flush  input  1  discard held and incoming instruction.
REQ-005 SHALL have ports: out_valid  output  1  decoded beat present; out_ready  input  1  ALU/execute consumes beat.
REQ-006 SHALL have ports: instructions  output  47  one-hot decoded op vector for the ALU; rs1_addr, rs2_addr, rd_addr  output  5 each; imm  output  32  sign-extended immediate; pc_out  output  32; illegal  output  1.

Function
REQ-007 SHALL map instructions bits: 0-9 ADD,SUB,XOR,OR,AND,SLL,SRL,SRA,SLT,SLTU; 10-18 ADDI,XORI,ORI,ANDI,SLLI,SRLI,SRAI,SLTI,SLTIU; 19-23 LB,LH,LW,LBU,LHU; 24-26 SB,SH,SW.
REQ-008 SHALL map bits 27-32 BEQ,BNE,BLT,BGE,BLTU,BGEU; 33 JAL; 34 JALR; 35 LUI; 36 AUIPC; 37-44 MUL,MULH,MULHSU,MULHU,DIV,DIVU,REM,REMU; 45 ECALL; 46 EBREAK.
REQ-009 SHALL keep instructions strictly one-hot when illegal=0 and all-zero when illegal=1.
REQ-010 SHALL assert illegal for any opcode/funct3/funct7 combination not in REQ-007/008; illegal beats still flow through the handshake.
REQ-011 SHALL form imm per I/S/B/U/J format, sign-extended to 32 bits (B/J with bit0=0, U with low 12 bits zero); imm=0 for R-type, ECALL, EBREAK, illegal.
REQ-012 SHALL drive rd_addr=0 for stores, branches, ECALL, EBREAK, illegal; rs2_addr=0 for formats without rs2; rs1_addr=0 for LUI, AUIPC, JAL.
REQ-013 SHALL register all decoded outputs in a single output stage: latency exactly 1 cycle from accepted input to out_valid.
REQ-014 SHALL drive in_ready = !out_valid || out_ready (combinational, no in_valid dependency).
REQ-015 SHALL accept a beat when in_valid && in_ready; SHALL clear out_valid when out_ready && !(in_valid accepted).
REQ-016 SHALL hold all outputs stable while out_valid && !out_ready.
REQ-017 SHALL, on flush, clear out_valid next cycle and drop any beat offered that cycle; flush outranks in_valid and out_ready.
REQ-018 SHALL support back-to-back accepts with out_ready held high: one beat per cycle, no bubbles.
REQ-019 SHALL pass in_pc to pc_out unchanged alongside its beat.

Reset
REQ-020 SHALL, on rst, drive out_valid=0, illegal=0, instructions=0, rs1/rs2/rd_addr=0, imm=0, pc_out=0 at next edge.
REQ-021 SHALL drop any held or incoming beat on rst mid-operation; rst outranks flush.
REQ-022 SHALL have in_ready=1 in the first cycle after reset.

Configuration
REQ-023 SHALL compile M-extension decode only when macro M_EXT_EN is defined.
REQ-024 SHALL, with M_EXT_EN, decode funct7=0000001 OP encodings to bits 37-44.
REQ-025 SHALL, without M_EXT_EN, tie bits 37-44 to 0 and flag those encodings illegal=1.

Verification
REQ-026 SHALL test: in_instr=0x002081B3 (ADD x3,x1,x2), out_ready=1 -> next cycle out_valid=1, instructions=bit0, rs1=1, rs2=2, rd=3, imm=0.
REQ-027 SHALL test: in_instr=0xFFF00293 (ADDI x5,x0,-1) -> instructions=bit10, rd=5, rs1=0, imm=0xFFFFFFFF.
REQ-028 SHALL test: in_instr=0x023100B3 (MUL x1,x2,x3) -> with M_EXT_EN bit37 set, illegal=0; without, instructions=0, illegal=1.
REQ-029 SHALL test: beat held, out_ready=0 for 3 cycles -> outputs unchanged, in_ready=0; out_ready=1 -> accepted beat appears next cycle.
REQ-030 SHALL test: flush and rst asserted with in_valid=1 and a held beat -> out_valid=0 next cycle, outputs per REQ-020 after rst.

Source files
------------

// File: rtl/instr_decode_stage.sv
// instr_decode_stage: RV32I(+M) decoder with a single registered valid/ready output stage.
// Define M_EXT_EN to decode the M-extension ops; otherwise those encodings are flagged illegal.
module instr_decode_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic        in_ready,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [46:0] instructions,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    output logic [4:0]  rd_addr,
    output logic [31:0] imm,
    output logic [31:0] pc_out,
    output logic        illegal
);
    localparam logic [2:0] F_R = 3'd0;
    localparam logic [2:0] F_I = 3'd1;
    localparam logic [2:0] F_S = 3'd2;
    localparam logic [2:0] F_B = 3'd3;
    localparam logic [2:0] F_U = 3'd4;
    localparam logic [2:0] F_J = 3'd5;
    localparam logic [2:0] F_N = 3'd6;

    logic [6:0]  w_opc;
    logic [6:0]  w_f7;
    logic [2:0]  w_f3;
    logic        w_hit;
    logic [5:0]  w_idx;
    logic [2:0]  w_fmt;
    logic [2:0]  w_f;
    logic [46:0] w_ops;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [4:0]  w_rd;
    logic [31:0] w_imm;
    logic        w_acc;

    logic        r_valid;
    logic [46:0] r_ops;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [4:0]  r_rd;
    logic [31:0] r_imm;
    logic [31:0] r_pc;
    logic        r_ill;

    assign w_opc = in_instr[6:0];
    assign w_f3  = in_instr[14:12];
    assign w_f7  = in_instr[31:25];

    // w_idx selects the one-hot bit; w_hit is low for every encoding outside the supported set
    always_comb begin
        w_hit = 1'b0;
        w_idx = 6'd0;
        w_fmt = F_N;
        case (w_opc)
            7'b0110011: begin
                w_fmt = F_R;
                if (w_f7 == 7'b0000000) begin
                    w_hit = 1'b1;
                    case (w_f3)
                        3'd0:    w_idx = 6'd0;
                        3'd1:    w_idx = 6'd5;
                        3'd2:    w_idx = 6'd8;
                        3'd3:    w_idx = 6'd9;
                        3'd4:    w_idx = 6'd2;
                        3'd5:    w_idx = 6'd6;
                        3'd6:    w_idx = 6'd3;
                        default: w_idx = 6'd4;
                    endcase
                end else if (w_f7 == 7'b0100000 && (w_f3 == 3'd0 || w_f3 == 3'd5)) begin
                    w_hit = 1'b1;
                    w_idx = (w_f3 == 3'd0) ? 6'd1 : 6'd7;
                end
`ifdef M_EXT_EN
                else if (w_f7 == 7'b0000001) begin
                    w_hit = 1'b1;
                    w_idx = 6'd37 + {3'b000, w_f3};
                end
`endif
            end
            7'b0010011: begin
                w_fmt = F_I;
                case (w_f3)
                    3'd0: begin w_hit = 1'b1; w_idx = 6'd10; end
                    3'd1: begin w_hit = (w_f7 == 7'b0000000); w_idx = 6'd14; end
                    3'd2: begin w_hit = 1'b1; w_idx = 6'd17; end
                    3'd3: begin w_hit = 1'b1; w_idx = 6'd18; end
                    3'd4: begin w_hit = 1'b1; w_idx = 6'd11; end
                    3'd5: begin
                        w_hit = (w_f7 == 7'b0000000) || (w_f7 == 7'b0100000);
                        w_idx = w_f7[5] ? 6'd16 : 6'd15;
                    end
                    3'd6: begin w_hit = 1'b1; w_idx = 6'd12; end
                    default: begin w_hit = 1'b1; w_idx = 6'd13; end
                endcase
            end
            7'b0000011: begin
                w_fmt = F_I;
                case (w_f3)
                    3'd0:    begin w_hit = 1'b1; w_idx = 6'd19; end
                    3'd1:    begin w_hit = 1'b1; w_idx = 6'd20; end
                    3'd2:    begin w_hit = 1'b1; w_idx = 6'd21; end
                    3'd4:    begin w_hit = 1'b1; w_idx = 6'd22; end
                    3'd5:    begin w_hit = 1'b1; w_idx = 6'd23; end
                    default: w_hit = 1'b0;
                endcase
            end
            7'b0100011: begin
                w_fmt = F_S;
                w_hit = (w_f3 < 3'd3);
                w_idx = 6'd24 + {3'b000, w_f3};
            end
            7'b1100011: begin
                w_fmt = F_B;
                w_hit = (w_f3 != 3'd2) && (w_f3 != 3'd3);
                w_idx = (w_f3 < 3'd2) ? 6'd27 + {3'b000, w_f3} : 6'd25 + {3'b000, w_f3};
            end
            7'b1101111: begin
                w_fmt = F_J;
                w_hit = 1'b1;
                w_idx = 6'd33;
            end
            7'b1100111: begin
                w_fmt = F_I;
                w_hit = (w_f3 == 3'd0);
                w_idx = 6'd34;
            end
            7'b0110111: begin
                w_fmt = F_U;
                w_hit = 1'b1;
                w_idx = 6'd35;
            end
            7'b0010111: begin
                w_fmt = F_U;
                w_hit = 1'b1;
                w_idx = 6'd36;
            end
            7'b1110011: begin
                w_fmt = F_N;
                w_hit = (in_instr == 32'h0000_0073) || (in_instr == 32'h0010_0073);
                w_idx = in_instr[20] ? 6'd46 : 6'd45;
            end
            default: w_hit = 1'b0;
        endcase
    end

    // Illegal words collapse to the no-operand format so every field reads zero
    assign w_f   = w_hit ? w_fmt : F_N;
    assign w_ops = w_hit ? (47'd1 << w_idx) : 47'd0;
    assign w_rs1 = (w_f == F_R || w_f == F_I || w_f == F_S || w_f == F_B) ? in_instr[19:15] : 5'd0;
    assign w_rs2 = (w_f == F_R || w_f == F_S || w_f == F_B) ? in_instr[24:20] : 5'd0;
    assign w_rd  = (w_f == F_R || w_f == F_I || w_f == F_U || w_f == F_J) ? in_instr[11:7] : 5'd0;

    always_comb begin
        w_imm = 32'd0;
        case (w_f)
            F_I:     w_imm = {{20{in_instr[31]}}, in_instr[31:20]};
            F_S:     w_imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            F_B:     w_imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
            F_U:     w_imm = {in_instr[31:12], 12'd0};
            F_J:     w_imm = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
            default: w_imm = 32'd0;
        endcase
    end

    assign in_ready = !r_valid || out_ready;
    assign w_acc    = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_ops   <= 47'd0;
            r_rs1   <= 5'd0;
            r_rs2   <= 5'd0;
            r_rd    <= 5'd0;
            r_imm   <= 32'd0;
            r_pc    <= 32'd0;
            r_ill   <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_acc) begin
            r_valid <= 1'b1;
            r_ops   <= w_ops;
            r_rs1   <= w_rs1;
            r_rs2   <= w_rs2;
            r_rd    <= w_rd;
            r_imm   <= w_imm;
            r_pc    <= in_pc;
            r_ill   <= !w_hit;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid    = r_valid;
    assign instructions = r_ops;
    assign rs1_addr     = r_rs1;
    assign rs2_addr     = r_rs2;
    assign rd_addr      = r_rd;
    assign imm          = r_imm;
    assign pc_out       = r_pc;
    assign illegal      = r_ill;
endmodule

// File: tb/tb_instr_decode_stage.sv
// tb_instr_decode_stage: directed decode vectors plus stall, flush and reset handshake checks.
module tb_instr_decode_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = 32'd0;
    logic [31:0] in_pc = 32'd0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [46:0] instructions;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic [31:0] imm;
    logic [31:0] pc_out;
    logic        illegal;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] instr;
        int          idx;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
    } vec_t;

    vec_t vq[$];

    instr_decode_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc),
        .in_ready(in_ready), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .instructions(instructions), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .imm(imm), .pc_out(pc_out), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [31:0] instr, input int idx, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] im);
        vec_t v;
        v.instr = instr;
        v.idx = idx;
        v.rs1 = rs1;
        v.rs2 = rs2;
        v.rd = rd;
        v.imm = im;
        vq.push_back(v);
    endtask

    task automatic chk_beat(input string tag, input vec_t v, input logic [31:0] pc);
        logic [63:0] ops;
        ops = (v.idx < 0) ? 64'd0 : (64'd1 << v.idx);
        chk({tag, ".valid"}, out_valid, 1);
        chk({tag, ".ops"}, instructions, ops);
        chk({tag, ".ill"}, illegal, (v.idx < 0) ? 1 : 0);
        chk({tag, ".rs1"}, rs1_addr, v.rs1);
        chk({tag, ".rs2"}, rs2_addr, v.rs2);
        chk({tag, ".rd"}, rd_addr, v.rd);
        chk({tag, ".imm"}, imm, v.imm);
        chk({tag, ".pc"}, pc_out, pc);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".valid"}, out_valid, 0);
        chk({tag, ".ops"}, instructions, 0);
        chk({tag, ".ill"}, illegal, 0);
        chk({tag, ".rs1"}, rs1_addr, 0);
        chk({tag, ".rs2"}, rs2_addr, 0);
        chk({tag, ".rd"}, rd_addr, 0);
        chk({tag, ".imm"}, imm, 0);
        chk({tag, ".pc"}, pc_out, 0);
    endtask

    initial begin
        add(32'h002081B3, 0, 5'd1, 5'd2, 5'd3, 32'h0);
        add(32'hFFF00293, 10, 5'd0, 5'd0, 5'd5, 32'hFFFFFFFF);
`ifdef M_EXT_EN
        add(32'h023100B3, 37, 5'd2, 5'd3, 5'd1, 32'h0);
`else
        add(32'h023100B3, -1, 5'd0, 5'd0, 5'd0, 32'h0);
`endif
        add(32'h0020A423, 26, 5'd1, 5'd2, 5'd0, 32'h8);
        add(32'hFE208EE3, 27, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFC);
        add(32'h123453B7, 35, 5'd0, 5'd0, 5'd7, 32'h12345000);
        add(32'h001000EF, 33, 5'd0, 5'd0, 5'd1, 32'h00000800);
        add(32'h40325213, 16, 5'd4, 5'd0, 5'd4, 32'h00000403);
        add(32'h00000073, 45, 5'd0, 5'd0, 5'd0, 32'h0);
        add(32'h00100073, 46, 5'd0, 5'd0, 5'd0, 32'h0);
        add(32'hFFFFFFFF, -1, 5'd0, 5'd0, 5'd0, 32'h0);
        add(32'h403110B3, -1, 5'd0, 5'd0, 5'd0, 32'h0);
        add(32'hFF812303, 21, 5'd2, 5'd0, 5'd6, 32'hFFFFFFF8);
        add(32'hFFFFF517, 36, 5'd0, 5'd0, 5'd10, 32'hFFFFF000);
        add(32'h000280E7, 34, 5'd5, 5'd0, 5'd1, 32'h0);

        step;
        step;
        rst = 1'b0;
        #1;
        chk_zero("reset");
        chk("reset.in_ready", in_ready, 1);

        // back-to-back stream with out_ready held high: one beat per cycle
        for (int i = 0; i < vq.size(); i++) begin
            in_valid = 1'b1;
            in_instr = vq[i].instr;
            in_pc = 32'h1000 + 32'(4 * i);
            step;
            chk_beat($sformatf("vec%0d", i), vq[i], 32'h1000 + 32'(4 * i));
        end
        in_valid = 1'b0;
        step;
        chk("drain.valid", out_valid, 0);

        // stall: held beat must not change while out_ready is low
        in_valid = 1'b1;
        in_instr = vq[0].instr;
        in_pc = 32'h2000;
        step;
        chk_beat("stallA", vq[0], 32'h2000);
        in_instr = vq[1].instr;
        in_pc = 32'h2004;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step;
            chk_beat($sformatf("hold%0d", i), vq[0], 32'h2000);
            chk($sformatf("hold%0d.in_ready", i), in_ready, 0);
        end
        out_ready = 1'b1;
        #1;
        chk("release.in_ready", in_ready, 1);
        step;
        chk_beat("stallB", vq[1], 32'h2004);
        in_valid = 1'b0;
        step;
        chk("stall.drain", out_valid, 0);

        // flush drops the held beat and the one offered alongside it
        in_valid = 1'b1;
        in_instr = vq[0].instr;
        in_pc = 32'h3000;
        out_ready = 1'b0;
        step;
        chk("flush.pre", out_valid, 1);
        in_instr = vq[1].instr;
        in_pc = 32'h3004;
        flush = 1'b1;
        step;
        chk("flush.valid", out_valid, 0);
        flush = 1'b0;
        in_valid = 1'b0;
        step;
        chk("flush.after", out_valid, 0);

        // reset with flush, in_valid and a held beat all active
        in_valid = 1'b1;
        in_instr = vq[3].instr;
        in_pc = 32'h4000;
        step;
        chk_beat("rstpre", vq[3], 32'h4000);
        in_instr = vq[1].instr;
        in_pc = 32'h4004;
        flush = 1'b1;
        rst = 1'b1;
        step;
        chk_zero("midrst");
        rst = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("midrst.in_ready", in_ready, 1);
        step;
        chk("midrst.after", out_valid, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
